// File: rtl/serial_pkg.sv
// Encodings shared by the serial transmit and receive blocks.
package serial_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Counter width for a 0..n-1 range, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/baud_tick_cnt.sv
// Enabled modulo-CLKS_PER_BIT counter; tc_o marks the last cycle of a bit.
module baud_tick_cnt
   import serial_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam int unsigned   CW     = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] TC_VAL = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = tc_o ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   end

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out frame transmitter: start, data LSB-first, stop.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit after the data.
module serial_tx_piso
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy
);

   localparam int unsigned   BW       = cnt_w(DATA_W);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   tx_state_t         state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] shift_nxt;
   logic [BW-1:0]     bit_q;
   logic              tx_out_q;
   logic              accept;
   logic              baud_tc;
`ifdef SERIAL_TX_PARITY_EN
   logic              par_q;
`endif

   assign tx_ready  = (state_q == IDLE);
   assign busy      = ~tx_ready;
   assign tx_out    = tx_out_q;
   assign accept    = en & tx_valid & tx_ready;
   assign shift_nxt = shreg_q >> 1;

   // Counter only runs inside a frame; acceptance restarts it at zero.
   baud_tick_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .en_i     (en & busy),
      .clr_i    (accept),
      .tc_o     (baud_tc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bit_q    <= '0;
         tx_out_q <= IDLE_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else if (accept) begin
         state_q  <= START;
         shreg_q  <= tx_data;
         bit_q    <= '0;
         tx_out_q <= START_BIT;
`ifdef SERIAL_TX_PARITY_EN
         par_q    <= ^tx_data;
`endif
      end else if (en && baud_tc) begin
         case (state_q)
            START: begin
               state_q  <= DATA;
               tx_out_q <= shreg_q[0];
            end
            DATA: begin
               if (bit_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_q  <= PARITY;
                  tx_out_q <= par_q;
`else
                  state_q  <= STOP;
                  tx_out_q <= STOP_BIT;
`endif
               end else begin
                  bit_q    <= bit_q + BW'(1);
                  shreg_q  <= shift_nxt;
                  tx_out_q <= shift_nxt[0];
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
               state_q  <= STOP;
               tx_out_q <= STOP_BIT;
            end
`endif
            STOP: begin
               state_q  <= IDLE;
               tx_out_q <= IDLE_LEVEL;
            end
            default: begin
               state_q  <= IDLE;
               tx_out_q <= IDLE_LEVEL;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_tx_piso.md
Name: serial_tx_piso

Overview:
- Parallel-in, serial-out frame transmitter.
- Launch-side counterpart to the enabled-DFF capture/shift-in path. It accepts a DATA_W-bit word over a valid/ready handshake and drives it onto one serial line as start bit, data LSB-first, optional parity and stop bit.
- Gated by the same global clock-enable style (`en`) used for our storage cells, so it can share a slow-tick domain with the receiving end.

Parameters:
- DATA_W, 8, payload width in bits (range 1..32).
- CLKS_PER_BIT, 4, enabled clock cycles per serial bit (1..65535).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when 0, all state holds.
- tx_valid  input  1  word offered.
- tx_data  input  DATA_W  word to send.
- tx_ready  output  1  block can accept a word; equals (state==IDLE).
- tx_out  output  1  serial line, registered, idles high.
- busy  output  1  frame in progress; equals !tx_ready.

Behaviour:
- Interface: one clock `clk`; reset `reset_n`, asynchronous, active-low.
- Reset values:
  - state=IDLE, tx_out=1, tx_ready=1, busy=0.
  - Shift register=0, bit counter=0, baud counter=0.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Accept: a word is accepted on a clk edge where tx_valid & tx_ready & en.
  - tx_data is latched into the shift register.
  - The baud counter is cleared and the state moves to START.
  - tx_data is not sampled at any other time.
- Latency: tx_out drops to 0 on the same edge that accepts the word, so it is visible the cycle after acceptance.
- Bit timing:
  - Each bit holds for exactly CLKS_PER_BIT enabled cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1; at terminal count it resets to 0 and the next bit is launched.
  - Counter width is $clog2(CLKS_PER_BIT), with a minimum of 1.
- START: tx_out=0.
- DATA:
  - tx_out=shreg[0]; the register shifts right at each bit boundary.
  - The bit counter (width $clog2(DATA_W), minimum 1) counts 0..DATA_W-1.
  - The last data bit leads to PARITY if enabled, otherwise to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT enabled cycles, then IDLE.
- Frame length: (DATA_W+2)*CLKS_PER_BIT enabled cycles, plus CLKS_PER_BIT with parity.
- Back-to-back words:
  - tx_ready rises the cycle after STOP completes.
  - A word held valid is accepted in that first IDLE cycle, giving a minimum of 1 extra enabled cycle of idle-high between frames.
- en=0: state, counters, shift register and tx_out all hold; no acceptance occurs even if tx_valid=1. A frame stretched by en gaps is otherwise unchanged.
- tx_valid dropped while in IDLE: no effect.
- tx_data changed mid-frame: no effect.
- reset_n asserted mid-frame:
  - tx_out returns to 1 immediately (asynchronous) and the frame is abandoned.
  - The first acceptance is possible on the first enabled edge after release.
- CLKS_PER_BIT=1: one bit per enabled cycle; no dead cycles except the mandatory IDLE cycle between frames.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA; tx_out = XOR of the latched word (even parity), held CLKS_PER_BIT enabled cycles.
  - Frame length = (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Decomposition:
- Package serial_pkg:
  - State enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
  - Shared so the matching receiver uses identical encodings.
- One natural sub-module, baud_tick_cnt: enabled modulo-CLKS_PER_BIT counter with clear input and terminal-count output. It is reused by the receive side.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset idle: reset_n=0 for 2 cycles, then release -> tx_out=1, tx_ready=1, busy=0; no transitions for 20 cycles with tx_valid=0.
- Single frame: en=1, CLKS_PER_BIT=4, tx_data=8'hA5 pulsed valid for 1 cycle.
  - tx_out sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_ready=0 for exactly 40 cycles.
- Back-to-back: tx_valid held high with 8'h01 then 8'h80 -> second start bit begins exactly 1 cycle after the first stop bit ends; both frames bit-exact.
- Enable gating: en toggled 1,0,1,0 during a frame of 8'h3C -> each bit spans exactly 4 en-high cycles; a valid asserted while en=0 in IDLE is not accepted until en=1.
- Mid-frame reset: reset_n pulsed low during data bit 3 -> tx_out=1 in the same cycle; tx_ready=1; a new word 8'hFF after release transmits correctly.
- Parity (SERIAL_TX_PARITY_EN defined): 8'h07 -> parity bit 1; 8'h03 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
